imem_rom_sync: RTL

Parametrised, clocked instruction memory for the CPU fetch stage. It replaces the asynchronous, enable-gated ROM.
- Registered read with a valid/ready request/response handshake.
- Self-initialising fill sequence after reset.
- Loader write port for patching program words at run time.
- Out-of-range address detection, reported as an error flag.

---
 rtl/imem_pkg.sv | 23 ++
 rtl/imem_fill_ctrl.sv | 69 ++++++
 rtl/imem_rom_sync.sv | 102 ++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the synchronous instruction ROM: FSM states,
// default widths and the power-up fill pattern.
package imem_pkg;

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_READY = 1'b1
  } imem_state_t;

  localparam int IMEM_DATA_W = 32;
  localparam int IMEM_ADDR_W = 7;

  // Fill words are produced at this width and narrowed by the caller, so the
  // same function serves any instruction width up to 64 bits.
  localparam int IMEM_FILL_W = 64;

  // Value written into word 'index' during the power-up fill.
  function automatic logic [IMEM_FILL_W-1:0] fill_word(input logic [31:0] index,
                                                       input logic        identity);
    return identity ? {32'd0, index} : '0;
  endfunction

endpackage

// File: rtl/imem_fill_ctrl.sv
// Power-up fill sequencer: walks every implemented word once after reset,
// then parks in READY until the next reset.
module imem_fill_ctrl
  import imem_pkg::*;
#(
  parameter int DATA_W        = IMEM_DATA_W,
  parameter int ADDR_W        = IMEM_ADDR_W,
  parameter int DEPTH         = 128,
  parameter int FILL_IDENTITY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy,
  output logic              isReady,
  output logic              fillWe,
  output logic [ADDR_W-1:0] fillAddr,
  output logic [DATA_W-1:0] fillData
);

  // The counter is address-wide: DEPTH never exceeds 2**ADDR_W, so the last
  // index always fits even when DEPTH is not a power of two.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  imem_state_t       state;
  imem_state_t       stateNext;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cntNext;

  // State and fill counter; reset always restarts a full refill from word 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_FILL;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // One word written per cycle in FILL; leave on the cycle the last word lands.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    fillWe    = 1'b0;
    busy      = 1'b0;
    isReady   = 1'b0;
    case (state)
      ST_FILL: begin
        busy   = 1'b1;
        fillWe = 1'b1;
        if (cnt == LAST_IDX) begin
          stateNext = ST_READY;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      ST_READY: begin
        isReady = 1'b1;
      end
      default: begin
        stateNext = ST_FILL;
      end
    endcase
  end

  assign fillAddr = cnt;
  assign fillData = DATA_W'(fill_word(32'(cnt), FILL_IDENTITY != 0));

endmodule

// File: rtl/imem_rom_sync.sv
// Clocked instruction memory for the fetch stage: self-filling storage,
// run-time loader port and a one-deep registered response with handshake.
module imem_rom_sync
  import imem_pkg::*;
#(
  parameter int DATA_W        = IMEM_DATA_W,
  parameter int ADDR_W        = IMEM_ADDR_W,
  parameter int DEPTH         = 128,
  parameter int FILL_IDENTITY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy
);

  // Compared one bit wider than the address so DEPTH == 2**ADDR_W is representable
  // and in that case no address is ever out of range.
  localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              isReady;
  logic              fillWe;
  logic [ADDR_W-1:0] fillAddr;
  logic [DATA_W-1:0] fillData;
  logic              memWe;
  logic [ADDR_W-1:0] memWaddr;
  logic [DATA_W-1:0] memWdata;
  logic              reqInRange;
  logic              ldInRange;
  logic              accept;

  imem_fill_ctrl #(
    .DATA_W        (DATA_W),
    .ADDR_W        (ADDR_W),
    .DEPTH         (DEPTH),
    .FILL_IDENTITY (FILL_IDENTITY)
  ) u_fill_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .busy     (busy),
    .isReady  (isReady),
    .fillWe   (fillWe),
    .fillAddr (fillAddr),
    .fillData (fillData)
  );

  assign reqInRange = {1'b0, req_addr} < DEPTH_CMP;
  assign ldInRange  = {1'b0, ld_addr}  < DEPTH_CMP;

  // The loader wins the cycle, so a read never shares an edge with a patch.
  assign req_ready = isReady & ~ld_en & (~rsp_valid | rsp_ready);
  assign accept    = req_valid & req_ready;

  // Single write port shared by the fill sequencer and the loader; loader
  // writes outside the implemented range are silently dropped.
  always_comb begin
    memWe    = 1'b0;
    memWaddr = fillAddr;
    memWdata = fillData;
    if (fillWe) begin
      memWe = 1'b1;
    end else if (isReady && ld_en && ldInRange) begin
      memWe    = 1'b1;
      memWaddr = ld_addr;
      memWdata = ld_data;
    end
  end

  // Storage contents carry no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memWaddr] <= memWdata;
    end
  end

  // Response register: load on accept, retire on consumer ready, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_err   <= ~reqInRange;
      rsp_data  <= reqInRange ? mem[req_addr] : '0;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
